// File: rtl/wrr_arbiter.sv
// ============================================================================
// Module   : wrr_arbiter
// Purpose  : Weighted round-robin arbiter with a registered grant that is
//            held until the shared resource reports done.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wrr_arbiter #(
  parameter int REQ_NUM  = 4,
  parameter int WEIGHT_W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [REQ_NUM-1:0]           reqs,
  input  logic [REQ_NUM*WEIGHT_W-1:0]  weights,
  input  logic                         done,
  output logic [REQ_NUM-1:0]           grants,
  output logic                         grant_valid,
  output logic [$clog2(REQ_NUM)-1:0]   grant_id
);

  localparam int ID_W = $clog2(REQ_NUM);
  localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(REQ_NUM - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t              r_state,  w_state_nxt;
  logic [REQ_NUM-1:0]  r_grants, w_grants_nxt;
  logic                r_valid,  w_valid_nxt;
  logic [ID_W-1:0]     r_id,     w_id_nxt;
  logic [ID_W-1:0]     r_ptr,    w_ptr_nxt;
  logic [WEIGHT_W-1:0] r_cnt,    w_cnt_nxt;

  logic [REQ_NUM-1:0]  w_mask;
  logic [REQ_NUM-1:0]  w_pick;
  logic [ID_W-1:0]     w_win;
  logic [ID_W-1:0]     w_win_inc;
  logic [WEIGHT_W-1:0] w_wt;
  logic [WEIGHT_W-1:0] w_ew;
  logic [WEIGHT_W:0]   w_cnt_inc;
  logic                w_rotate;

  // Cyclic search from r_ptr: prefer requesters at or above the pointer,
  // fall back to the lowest requester overall when none are above it.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      w_mask[i] = (ID_W'(i) >= r_ptr);
    end
    w_pick = (|(reqs & w_mask)) ? (reqs & w_mask) : reqs;
    w_win  = '0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (w_pick[i]) begin
        w_win = ID_W'(i);
      end
    end
  end

  assign w_wt      = weights[int'(w_win)*WEIGHT_W +: WEIGHT_W];
  assign w_ew      = (w_wt == '0) ? WEIGHT_W'(1) : w_wt;
  // One extra bit so a weight lowered below the running count cannot wrap.
  assign w_cnt_inc = (w_win == r_ptr) ? ({1'b0, r_cnt} + (WEIGHT_W+1)'(1))
                                      : (WEIGHT_W+1)'(1);
  assign w_rotate  = (w_cnt_inc >= {1'b0, w_ew});
  assign w_win_inc = (w_win == c_LAST_ID) ? '0 : (w_win + ID_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_grants <= '0;
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grants <= w_grants_nxt;
      r_valid  <= w_valid_nxt;
      r_id     <= w_id_nxt;
      r_ptr    <= w_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grants_nxt = r_grants;
    w_valid_nxt  = r_valid;
    w_id_nxt     = r_id;
    w_ptr_nxt    = r_ptr;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (|reqs) begin
          w_state_nxt  = ST_BUSY;
          w_grants_nxt = REQ_NUM'(1) << w_win;
          w_valid_nxt  = 1'b1;
          w_id_nxt     = w_win;
          if (w_rotate) begin
            w_ptr_nxt = w_win_inc;
            w_cnt_nxt = '0;
          end else begin
            w_ptr_nxt = w_win;
            w_cnt_nxt = w_cnt_inc[WEIGHT_W-1:0];
          end
        end
      end
      ST_BUSY: begin
        if (done) begin
          w_state_nxt  = ST_IDLE;
          w_grants_nxt = '0;
          w_valid_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_grants_nxt = '0;
        w_valid_nxt  = 1'b0;
      end
    endcase
  end

  assign grants      = r_grants;
  assign grant_valid = r_valid;
  assign grant_id    = r_id;

endmodule

`default_nettype wire

// File: tb/tb_wrr_arbiter.sv
// ============================================================================
// Module   : tb_wrr_arbiter
// Purpose  : Directed self-checking bench for wrr_arbiter (N=4, W=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wrr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  reqs;
  logic [15:0] weights;
  logic        done;
  logic [3:0]  grants;
  logic        grant_valid;
  logic [1:0]  grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  wrr_arbiter #(
    .REQ_NUM (4),
    .WEIGHT_W(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reqs       (reqs),
    .weights    (weights),
    .done       (done),
    .grants     (grants),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one grant to requester id and retire it with a single-cycle done.
  task automatic do_grant(input string tag, input int id);
    @(posedge clk); #1;
    check({tag, " grants"}, 32'(grants), 32'(4'b0001 << id));
    check({tag, " valid"}, 32'(grant_valid), 32'd1);
    check({tag, " id"}, 32'(grant_id), 32'(id));
    done = 1'b1;
    @(posedge clk); #1;
    check({tag, " idle gap"}, 32'(grants), 32'd0);
    done = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    reqs    = 4'b0000;
    weights = 16'h1111;
    done    = 1'b0;

    // Reset state
    #12;
    check("rst grants", 32'(grants), 32'd0);
    check("rst valid", 32'(grant_valid), 32'd0);
    check("rst id", 32'(grant_id), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Asynchronous reset while busy on requester 2
    reqs = 4'b0100;
    @(posedge clk); #1;
    check("pre-rst grants", 32'(grants), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("async rst grants", 32'(grants), 32'd0);
    check("async rst valid", 32'(grant_valid), 32'd0);
    check("async rst id", 32'(grant_id), 32'd0);
    #1 rst_n = 1'b1;
    reqs = 4'b1111;

    // Equal weights: 0,1,2,3,0,1
    do_grant("eq0", 0);
    do_grant("eq1", 1);
    do_grant("eq2", 2);
    do_grant("eq3", 3);
    do_grant("eq4", 0);
    do_grant("eq5", 1);

    // Weighted {3,1,2,1}: 0,0,0,1,2,2,3,0,0,0
    pulse_reset();
    weights = 16'h1213;
    do_grant("wt0", 0);
    do_grant("wt1", 0);
    do_grant("wt2", 0);
    do_grant("wt3", 1);
    do_grant("wt4", 2);
    do_grant("wt5", 2);
    do_grant("wt6", 3);
    do_grant("wt7", 0);
    do_grant("wt8", 0);
    do_grant("wt9", 0);

    // Zero weights behave as one; pointer skip from ptr=1 to requester 3
    pulse_reset();
    weights = 16'h0000;
    reqs    = 4'b1001;
    do_grant("zw0", 0);
    do_grant("zw1", 3);
    do_grant("zw2", 0);
    do_grant("zw3", 3);
    do_grant("zw4", 0);
    check("zw ptr", 32'(dut.r_ptr), 32'd1);
    do_grant("zw5", 3);

    // Lock and hold: grant stays on 2 after its request drops
    weights = 16'h1111;
    reqs    = 4'b0100;
    @(posedge clk); #1;
    check("lock grant", 32'(grants), 32'h4);
    reqs = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("lock hold", 32'(grants), 32'h4);
    end
    done = 1'b1;
    @(posedge clk); #1;
    check("lock release", 32'(grants), 32'd0);
    check("lock release valid", 32'(grant_valid), 32'd0);
    check("idle id held", 32'(grant_id), 32'd2);
    @(posedge clk); #1;
    check("done in idle", 32'(grant_valid), 32'd0);
    done = 1'b0;

    // Single requester 1 with weight 2: cnt alternates 1,0
    weights = 16'h0020;
    reqs    = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      do_grant("single", 1);
      check("single cnt", 32'(dut.r_cnt), ((k % 2) == 0) ? 32'd1 : 32'd0);
    end

    reqs = 4'b0000;
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
